collision_scheduler: RTL and testbench

Frame-driven sequencer that time-multiplexes one shared box-overlap comparator across all collision checks for a frame:
- 14 stair landings
- doodle vs monster
- bullet vs monster

It replaces 14+ parallel comparator sets with one, snapshots positions at frame start, and publishes one coherent result set per frame. It sits between the object-position logic (doodle, stairs, monster, bullet) and the game-state/physics logic.

---
 rtl/collision_pkg.sv | 20 ++
 rtl/box_cmp.sv | 26 ++
 rtl/collision_scheduler.sv | 151 +++++++++++++++
 tb/tb_collision_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// collision_pkg: shared state encoding, snapshot/result records and clamp helper for the collision scheduler
package collision_pkg;
   typedef enum logic [2:0] {IDLE, STAIR, MONS, BULL, DONE} state_t;
   localparam int NUM_STAIRS_MAX = 16;
   localparam int KW = $clog2(NUM_STAIRS_MAX);
   localparam int LAND_TOL_DEF = 8;
   localparam int FALL_LIMIT_DEF = 100;
   typedef struct packed {
      logic [9:0] bx, by, bs, step, ss, mx, my, msx, msy, ux, uy, us;
      logic       mact, ufly;
   } snap_t;
   typedef struct packed {
      logic          land;
      logic [KW-1:0] idx;
      logic          death, beat, hit;
   } res_t;
   function automatic logic [10:0] sub_clamp(input logic [10:0] a, input logic [10:0] b);
      return (a > b) ? a - b : 11'd0;
   endfunction
endpackage

// File: rtl/box_cmp.sv
// box_cmp: combinational 11-bit two-axis box overlap test with selectable edge inclusion
module box_cmp
   import collision_pkg::*;
(
   input  logic [10:0] ax, ay, ahx, ahy,
   input  logic [10:0] bx, by, bhx, bhy,
   input  logic        incl,
   output logic        hit
);
   logic [10:0] a_xl, a_xh, a_yl, a_yh, b_xl, b_xh, b_yl, b_yh;
   logic        x_ok, y_ok;
   // box edges (low edges clamp at 0), then per-axis overlap; touching edges count only when incl
   always_comb begin
      a_xl = sub_clamp(ax, ahx);
      a_xh = ax + ahx;
      a_yl = sub_clamp(ay, ahy);
      a_yh = ay + ahy;
      b_xl = sub_clamp(bx, bhx);
      b_xh = bx + bhx;
      b_yl = sub_clamp(by, bhy);
      b_yh = by + bhy;
      x_ok = incl ? (a_xh >= b_xl && a_xl <= b_xh) : (a_xh > b_xl && a_xl < b_xh);
      y_ok = incl ? (a_yh >= b_yl && a_yl <= b_yh) : (a_yh > b_yl && a_yl < b_yh);
      hit  = x_ok && y_ok;
   end
endmodule

// File: rtl/collision_scheduler.sv
// collision_scheduler: per-frame sequencer sharing one box comparator across stair, monster and bullet checks
module collision_scheduler
   import collision_pkg::*;
#(
   parameter int NUM_STAIRS = 14,
   parameter int LAND_TOL   = LAND_TOL_DEF,
   parameter int FALL_LIMIT = FALL_LIMIT_DEF
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        frame_clk,
   input  logic [9:0]                  Ball_X_Pos,
   input  logic [9:0]                  Ball_Y_Pos,
   input  logic [9:0]                  Ball_Size,
   input  logic [9:0]                  Ball_Y_Step,
   input  logic [NUM_STAIRS-1:0][9:0]  stair_x,
   input  logic [NUM_STAIRS-1:0][9:0]  stair_y,
   input  logic [9:0]                  stair_size,
   input  logic [9:0]                  monster_x,
   input  logic [9:0]                  monster_y,
   input  logic [9:0]                  monster_size_x,
   input  logic [9:0]                  monster_size_y,
   input  logic                        monster_active,
   input  logic [9:0]                  bullet_x,
   input  logic [9:0]                  bullet_y,
   input  logic [9:0]                  bullet_size,
   input  logic                        bullet_fly,
   output logic                        land,
   output logic [3:0]                  land_idx,
   output logic                        death,
   output logic                        beat_mons,
   output logic                        hit,
   output logic                        done,
   output logic                        busy,
   output logic                        overrun
);
   localparam logic [KW-1:0] K_LAST = KW'(NUM_STAIRS - 1);
   state_t                     state_q, state_d;
   logic [KW-1:0]              k_q, k_d;
   logic [1:0]                 fs_q, fs_d;
   snap_t                      snap_q, snap_d;
   logic [NUM_STAIRS-1:0][9:0] sx_q, sx_d, sy_q, sy_d;
   res_t                       acc_q, acc_d, out_q, out_d;
   logic                       ovr_q, ovr_d;
   logic                       fe, is_st, is_bu, falling, en, chk, cmp_hit;
   logic [10:0]                c_ax, c_ay, c_ahx, c_ahy, c_bx, c_by, c_bhx, c_bhy;

   assign fe = fs_q[0] & ~fs_q[1];

   box_cmp u_cmp (
      .ax(c_ax), .ay(c_ay), .ahx(c_ahx), .ahy(c_ahy),
      .bx(c_bx), .by(c_by), .bhx(c_bhx), .bhy(c_bhy),
      .incl(is_st), .hit(cmp_hit)
   );

   // route the snapshot fields for the current phase into the shared comparator
   always_comb begin
      is_st   = state_q == STAIR;
      is_bu   = state_q == BULL;
      falling = 11'(snap_q.step) < 11'(FALL_LIMIT);
      c_ax    = 11'(is_bu ? snap_q.ux : snap_q.bx);
      c_ahx   = 11'(is_bu ? snap_q.us : snap_q.bs);
      c_ay    = is_st ? 11'(snap_q.by) + 11'(snap_q.bs) + 11'(snap_q.step) : 11'(is_bu ? snap_q.uy : snap_q.by);
      c_ahy   = is_st ? 11'd0 : c_ahx;
      c_bx    = 11'(is_st ? sx_q[k_q] : snap_q.mx);
      c_bhx   = 11'(is_st ? snap_q.ss : snap_q.msx);
      c_by    = 11'(is_st ? sy_q[k_q] : snap_q.my);
      c_bhy   = is_st ? 11'(LAND_TOL) : 11'(snap_q.msy);
      en      = is_st ? falling : snap_q.mact && (!is_bu || snap_q.ufly);
      chk     = cmp_hit && en;
   end

   // sequencing: snapshot on frame edge, scan stairs, monster, bullet, then publish
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      fs_d    = {fs_q[0], frame_clk};
      snap_d  = snap_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      acc_d   = acc_q;
      out_d   = out_q;
      ovr_d   = ovr_q | (fe && state_q != IDLE);
      case (state_q)
         IDLE: if (fe) begin
            state_d = STAIR;
            k_d     = '0;
            acc_d   = '0;
            sx_d    = stair_x;
            sy_d    = stair_y;
            snap_d  = '{bx: Ball_X_Pos, by: Ball_Y_Pos, bs: Ball_Size, step: Ball_Y_Step,
                        ss: stair_size, mx: monster_x, my: monster_y, msx: monster_size_x,
                        msy: monster_size_y, ux: bullet_x, uy: bullet_y, us: bullet_size,
                        mact: monster_active, ufly: bullet_fly};
         end
         STAIR: begin
            if (chk && !acc_q.land) begin
               acc_d.land = 1'b1;
               acc_d.idx  = k_q;
            end
            k_d     = k_q + 1'b1;
            state_d = (k_q == K_LAST) ? MONS : STAIR;
         end
         MONS: begin
            acc_d.beat  = chk && falling;
            acc_d.death = chk && !falling;
            state_d     = BULL;
         end
         BULL: begin
            out_d     = acc_q;
            out_d.hit = chk;
            state_d   = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // all state registers, cleared by synchronous reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         fs_q    <= '0;
         snap_q  <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         fs_q    <= fs_d;
         snap_q  <= snap_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         ovr_q   <= ovr_d;
      end
   end

   assign land      = out_q.land;
   assign land_idx  = out_q.idx;
   assign death     = out_q.death;
   assign beat_mons = out_q.beat;
   assign hit       = out_q.hit;
   assign done      = state_q == DONE;
   assign busy      = state_q inside {STAIR, MONS, BULL};
   assign overrun   = ovr_q;
endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler: scoreboard bench with a rule-level reference model of the frame collision results
module tb_collision_scheduler;
   localparam int NS = 14;
   typedef struct packed {
      logic       land;
      logic [3:0] idx;
      logic       death, beat, hit;
   } exp_t;

   logic Clk = 0, Reset = 1, frame_clk = 0;
   int bx, by, bs, step, ss, mx, my, msx, msy, ux, uy, us;
   bit mact, fly;
   int sx[NS], sy[NS];
   logic [NS-1:0][9:0] sxp, syp;
   logic land, death, beat_mons, hit, done, busy, overrun;
   logic [3:0] land_idx;
   exp_t exp_q[$];
   int start_q[$];
   exp_t last, cur;
   int cyc = 0, errs = 0, checks = 0, st;

   always_comb for (int i = 0; i < NS; i++) begin
      sxp[i] = 10'(sx[i]);
      syp[i] = 10'(sy[i]);
   end

   collision_scheduler #(.NUM_STAIRS(NS)) dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
      .Ball_X_Pos(10'(bx)), .Ball_Y_Pos(10'(by)), .Ball_Size(10'(bs)), .Ball_Y_Step(10'(step)),
      .stair_x(sxp), .stair_y(syp), .stair_size(10'(ss)),
      .monster_x(10'(mx)), .monster_y(10'(my)), .monster_size_x(10'(msx)), .monster_size_y(10'(msy)),
      .monster_active(mact), .bullet_x(10'(ux)), .bullet_y(10'(uy)), .bullet_size(10'(us)),
      .bullet_fly(fly), .land(land), .land_idx(land_idx), .death(death), .beat_mons(beat_mons),
      .hit(hit), .done(done), .busy(busy), .overrun(overrun)
   );

   always #10 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic int lo(input int c, input int h);
      return c > h ? c - h : 0;
   endfunction

   // expected frame results straight from the landing/overlap rules
   function automatic exp_t model();
      exp_t e = '0;
      int bot = by + bs + step;
      bit fall = step < 100;
      bit m, b;
      for (int i = NS - 1; i >= 0; i--)
         if (fall && bx + bs >= lo(sx[i], ss) && lo(bx, bs) <= sx[i] + ss &&
             bot >= lo(sy[i], 8) && bot <= sy[i] + 8) begin
            e.land = 1;
            e.idx  = 4'(i);
         end
      m = mact && bx + bs > lo(mx, msx) && lo(bx, bs) < mx + msx && by + bs > lo(my, msy) && lo(by, bs) < my + msy;
      b = mact && fly && ux + us > lo(mx, msx) && lo(ux, us) < mx + msx && uy + us > lo(my, msy) && lo(uy, us) < my + msy;
      e.beat  = m && fall;
      e.death = m && !fall;
      e.hit   = b;
      return e;
   endfunction

   task automatic far();
      bx = 100; by = 200; bs = 8; step = 2; ss = 20;
      for (int i = 0; i < NS; i++) begin sx[i] = 900; sy[i] = 900; end
      mx = 900; my = 900; msx = 10; msy = 10; mact = 0;
      ux = 50; uy = 900; us = 3; fly = 0;
   endtask

   task automatic rnd();
      bx = $urandom_range(100, 160); by = $urandom_range(100, 220); bs = $urandom_range(0, 15);
      step = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 1023) : $urandom_range(0, 40);
      ss = $urandom_range(0, 20);
      for (int i = 0; i < NS; i++) begin sx[i] = $urandom_range(80, 200); sy[i] = $urandom_range(100, 300); end
      mx = $urandom_range(90, 220); my = $urandom_range(90, 220);
      msx = $urandom_range(0, 30); msy = $urandom_range(0, 30); mact = ($urandom_range(0, 1) == 1);
      ux = $urandom_range(90, 220); uy = $urandom_range(90, 220); us = $urandom_range(0, 10);
      fly = ($urandom_range(0, 1) == 1);
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge Clk);
         seen = done;
      end
      checks++;
      if (!seen) begin
         errs++;
         $display("FAIL done_timeout: got no done within 40 cycles expected a done pulse");
      end
      @(posedge Clk); #1;
   endtask

   // raise a frame edge, scramble live inputs once the snapshot is taken, optionally re-edge mid-scan
   task automatic frame(input bit push, input bit ovr_edge);
      @(posedge Clk); #1;
      frame_clk = 1;
      if (push) begin
         exp_q.push_back(model());
         start_q.push_back(cyc);
      end
      repeat (2) @(posedge Clk);
      #1 frame_clk = 0;
      rnd();
      if (ovr_edge) begin
         repeat (3) @(posedge Clk);
         #1 frame_clk = 1;
         repeat (2) @(posedge Clk);
         #1 check("ovr_busy", int'(busy), 1);
         check("ovr_set", int'(overrun), 1);
         frame_clk = 0;
      end
      if (push) wait_done();
   endtask

   // monitor: pop and compare on every done, otherwise outputs must hold
   always @(negedge Clk) begin
      if (Reset) last = '0;
      else if (done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL spurious_done: got done=1 expected no pending frame");
         end else begin
            cur = exp_q.pop_front();
            st  = start_q.pop_front();
            check("land", int'(land), int'(cur.land));
            check("land_idx", int'(land_idx), int'(cur.idx));
            check("death", int'(death), int'(cur.death));
            check("beat_mons", int'(beat_mons), int'(cur.beat));
            check("hit", int'(hit), int'(cur.hit));
            check("latency", cyc - st, NS + 4);
            last = cur;
         end
      end else check("hold", int'({land, land_idx, death, beat_mons, hit}), int'(last));
   end

   initial begin
      far();
      repeat (3) @(posedge Clk);
      #1 Reset = 0;
      repeat (4) @(posedge Clk);
      #1 check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_land", int'(land), 0);
      far(); sx[5] = 105; sy[5] = 216;
      frame(1, 0);
      check("t1_land", int'(land), 1);
      check("t1_idx", int'(land_idx), 5);
      far(); sx[3] = 105; sy[3] = 216; sx[9] = 105; sy[9] = 216;
      frame(1, 0);
      check("t2_idx", int'(land_idx), 3);
      far(); sx[3] = 105; sy[3] = 216; sx[9] = 105; sy[9] = 216; step = 150;
      frame(1, 0);
      check("t2_noland", int'({land, land_idx}), 0);
      far(); mx = 110; my = 200; mact = 1;
      frame(1, 0);
      check("t3_beat", int'({death, beat_mons}), 1);
      far(); mx = 110; my = 200; mact = 1; step = 900;
      frame(1, 0);
      check("t3_death", int'({death, beat_mons}), 2);
      far(); mx = 110; my = 200; mact = 0;
      frame(1, 0);
      check("t3_inactive", int'({death, beat_mons}), 0);
      far(); mx = 302; my = 102; mact = 1; ux = 300; uy = 100; us = 3; fly = 1;
      frame(1, 0);
      check("t4_hit", int'(hit), 1);
      far(); mx = 302; my = 102; mact = 1; ux = 300; uy = 100; us = 3; fly = 0;
      frame(1, 0);
      check("t4_nofly", int'(hit), 0);
      far(); bx = 2; bs = 8; step = 0; ss = 0; sx[0] = 0; sy[0] = 200;
      frame(1, 0);
      check("b_incl_land", int'({land, land_idx}), 16);
      far(); mx = 118; my = 200; mact = 1;
      frame(1, 0);
      check("b_strict_edge", int'({death, beat_mons}), 0);
      far(); mx = 110; my = 200; mact = 1; step = 100;
      frame(1, 0);
      check("b_fall_limit", int'({death, beat_mons}), 2);
      far(); sx[5] = 105; sy[5] = 216;
      frame(1, 1);
      repeat (25) @(posedge Clk);
      #1 check("ovr_sticky", int'(overrun), 1);
      check("ovr_idle", int'(busy), 0);
      check("ovr_first_snap", int'({land, land_idx}), 21);
      far(); sx[5] = 105; sy[5] = 216; mx = 110; my = 200; mact = 1;
      frame(0, 0);
      repeat (5) @(posedge Clk);
      #1 Reset = 1;
      @(posedge Clk);
      #1 Reset = 0;
      repeat (25) @(posedge Clk);
      #1 check("rm_outputs", int'({land, land_idx, death, beat_mons, hit}), 0);
      check("rm_overrun", int'(overrun), 0);
      check("rm_busy", int'(busy), 0);
      for (int n = 0; n < 40; n++) begin
         rnd();
         frame(1, 0);
      end
      repeat (5) @(posedge Clk);
      #1 check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
